// File: rtl/mini_src_pkg.sv
// Shared constants and types for the mini-SRC datapath blocks.
package mini_src_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int NUM_GP_REGS = 16;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [3:0]            reg_sel_t;

endpackage : mini_src_pkg

// File: rtl/data_path_if.sv
// Control-side bundle of the register-file slice: write enables, write data,
// bus select, and the bus plus per-register observation outputs.
interface data_path_if;
  import mini_src_pkg::*;

  logic [NUM_GP_REGS-1:0] gp_enable;
  word_t                  gp_write_data;
  reg_sel_t               gp_register_select;
  word_t                  BusMuxOut;
  word_t gp_out0,  gp_out1,  gp_out2,  gp_out3;
  word_t gp_out4,  gp_out5,  gp_out6,  gp_out7;
  word_t gp_out8,  gp_out9,  gp_out10, gp_out11;
  word_t gp_out12, gp_out13, gp_out14, gp_out15;

  // Control unit side: drives enables/data/select, observes the registers.
  modport master (
    output gp_enable, gp_write_data, gp_register_select,
    input  BusMuxOut,
    input  gp_out0,  gp_out1,  gp_out2,  gp_out3,
    input  gp_out4,  gp_out5,  gp_out6,  gp_out7,
    input  gp_out8,  gp_out9,  gp_out10, gp_out11,
    input  gp_out12, gp_out13, gp_out14, gp_out15
  );

  // Register file side.
  modport slave (
    input  gp_enable, gp_write_data, gp_register_select,
    output BusMuxOut,
    output gp_out0,  gp_out1,  gp_out2,  gp_out3,
    output gp_out4,  gp_out5,  gp_out6,  gp_out7,
    output gp_out8,  gp_out9,  gp_out10, gp_out11,
    output gp_out12, gp_out13, gp_out14, gp_out15
  );

endinterface : data_path_if

// File: rtl/gp_register.sv
// One general-purpose register: loads data_i on a rising edge when enabled,
// cleared asynchronously by an active-low clear.
module gp_register
  import mini_src_pkg::*;
#(
  parameter word_t RESET_VALUE = '0
) (
  input  logic  clock,
  input  logic  clear,
  input  logic  enable_i,
  input  word_t data_i,
  output word_t data_o
);

  word_t data_q;
  word_t data_d;

  assign data_d = enable_i ? data_i : data_q;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values; clear is in the sensitivity list, making it async.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule : gp_register

// File: rtl/data_path.sv
// Register-file slice of the mini-SRC datapath: sixteen GP registers with
// per-register write enables and a combinational bus multiplexer.
module data_path
  import mini_src_pkg::*;
#(
  parameter word_t RESET_VALUE = '0
) (
  input  logic        clock,
  input  logic        clear,
  data_path_if.slave  dp
);

  word_t gp_q [NUM_GP_REGS];

  for (genvar gi = 0; gi < NUM_GP_REGS; gi++) begin : g_reg
    gp_register #(
      .RESET_VALUE (RESET_VALUE)
    ) u_reg (
      .clock    (clock),
      .clear    (clear),
      .enable_i (dp.gp_enable[gi]),
      .data_i   (dp.gp_write_data),
      .data_o   (gp_q[gi])
    );
  end

  // All 16 select codes map to a register, so the bus is never undriven;
  // no write-through bypass: the bus shows flop outputs only.
  assign dp.BusMuxOut = gp_q[dp.gp_register_select];

  assign dp.gp_out0  = gp_q[0];
  assign dp.gp_out1  = gp_q[1];
  assign dp.gp_out2  = gp_q[2];
  assign dp.gp_out3  = gp_q[3];
  assign dp.gp_out4  = gp_q[4];
  assign dp.gp_out5  = gp_q[5];
  assign dp.gp_out6  = gp_q[6];
  assign dp.gp_out7  = gp_q[7];
  assign dp.gp_out8  = gp_q[8];
  assign dp.gp_out9  = gp_q[9];
  assign dp.gp_out10 = gp_q[10];
  assign dp.gp_out11 = gp_q[11];
  assign dp.gp_out12 = gp_q[12];
  assign dp.gp_out13 = gp_q[13];
  assign dp.gp_out14 = gp_q[14];
  assign dp.gp_out15 = gp_q[15];

endmodule : data_path

// File: tb/tb_data_path.sv
// Scoreboard bench for data_path: stimulus pushes expectations from a simple
// array model, a separate monitor pops and compares against the DUT.
module tb_data_path;
  import mini_src_pkg::*;

  typedef struct {
    int    idx;      // -1 = BusMuxOut, 0..15 = gp_outN
    word_t exp;
    string name;
  } exp_t;

  logic  clk;
  logic  clear;
  int    n_checks;
  int    n_errors;
  exp_t  exp_q[$];
  event  sample_ev;
  word_t model [NUM_GP_REGS];
  word_t outs  [NUM_GP_REGS];

  data_path_if dp_if ();

  data_path #(.RESET_VALUE('0)) u_dut (
    .clock (clk),
    .clear (clear),
    .dp    (dp_if)
  );

  assign outs[0]  = dp_if.gp_out0;
  assign outs[1]  = dp_if.gp_out1;
  assign outs[2]  = dp_if.gp_out2;
  assign outs[3]  = dp_if.gp_out3;
  assign outs[4]  = dp_if.gp_out4;
  assign outs[5]  = dp_if.gp_out5;
  assign outs[6]  = dp_if.gp_out6;
  assign outs[7]  = dp_if.gp_out7;
  assign outs[8]  = dp_if.gp_out8;
  assign outs[9]  = dp_if.gp_out9;
  assign outs[10] = dp_if.gp_out10;
  assign outs[11] = dp_if.gp_out11;
  assign outs[12] = dp_if.gp_out12;
  assign outs[13] = dp_if.gp_out13;
  assign outs[14] = dp_if.gp_out14;
  assign outs[15] = dp_if.gp_out15;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input word_t actual, input word_t expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Monitor: consumes every queued expectation when the stimulus side strobes.
  initial begin
    forever begin
      @(sample_ev);
      while (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.idx < 0) check(e.name, dp_if.BusMuxOut, e.exp);
        else           check(e.name, outs[e.idx], e.exp);
      end
    end
  end

  task automatic drain();
    int k;
    -> sample_ev;
    for (k = 0; k < 4 && exp_q.size() != 0; k++) #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL monitor_timeout: got %0d pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic expect_bus(input string tag);
    exp_t e;
    e.idx  = -1;
    e.exp  = model[dp_if.gp_register_select];
    e.name = $sformatf("%s bus sel=%0d", tag, dp_if.gp_register_select);
    exp_q.push_back(e);
    drain();
  endtask

  task automatic expect_all_regs(input string tag);
    for (int i = 0; i < NUM_GP_REGS; i++) begin
      exp_t e;
      e.idx  = i;
      e.exp  = model[i];
      e.name = $sformatf("%s gp_out%0d", tag, i);
      exp_q.push_back(e);
    end
    drain();
  endtask

  task automatic sweep_bus(input string tag);
    for (int s = 0; s < NUM_GP_REGS; s++) begin
      dp_if.gp_register_select = reg_sel_t'(s);
      #1;
      expect_bus(tag);
    end
  endtask

  // One rising edge; the model applies the write rule, then outputs settle.
  task automatic step();
    @(posedge clk);
    if (clear) begin
      for (int i = 0; i < NUM_GP_REGS; i++)
        if (dp_if.gp_enable[i]) model[i] = dp_if.gp_write_data;
    end
    #1;
  endtask

  task automatic drive(input logic [15:0] en, input word_t data);
    @(negedge clk);
    dp_if.gp_enable     = en;
    dp_if.gp_write_data = data;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < NUM_GP_REGS; i++) model[i] = '0;

    // Reset with writes requested: everything must read zero.
    clear = 1'b0;
    dp_if.gp_enable          = 16'hFFFF;
    dp_if.gp_write_data      = $urandom;
    dp_if.gp_register_select = '0;
    step();
    dp_if.gp_write_data = $urandom;
    step();
    expect_all_regs("reset");
    sweep_bus("reset");

    @(negedge clk);
    clear = 1'b1;
    dp_if.gp_enable = '0;

    // Walking write, one register per edge.
    for (int i = 0; i < NUM_GP_REGS; i++) begin
      drive(16'(1) << i, word_t'(i));
      step();
    end
    expect_all_regs("walk");
    sweep_bus("walk");

    // Hold: no enables, data must not land anywhere.
    drive(16'h0000, 32'hDEADBEEF);
    repeat (5) step();
    expect_all_regs("hold");

    // Multi-enable: R0 and R15 together.
    drive(16'h8001, 32'hA5A5A5A5);
    step();
    expect_all_regs("multi");

    // Same-cycle read/write of R3: old value before the edge, new after.
    @(negedge clk);
    dp_if.gp_register_select = 4'd3;
    dp_if.gp_enable          = 16'h0008;
    dp_if.gp_write_data      = 32'h12345678;
    #1;
    expect_bus("rw_before");
    step();
    expect_bus("rw_after");

    // Randomised writes with random selects.
    for (int n = 0; n < 24; n++) begin
      drive(16'($urandom), $urandom);
      dp_if.gp_register_select = reg_sel_t'($urandom_range(0, 15));
      step();
      expect_bus("rand");
      if (n % 8 == 7) expect_all_regs("rand");
    end

    // Async reset between edges while all enables are high.
    drive(16'hFFFF, 32'hCAFEF00D);
    step();
    #2;
    clear = 1'b0;
    for (int i = 0; i < NUM_GP_REGS; i++) model[i] = '0;
    #1;
    expect_all_regs("async_clr");
    sweep_bus("async_clr");
    step();
    expect_all_regs("clr_edge_ignored");

    // Release and write R7 only.
    @(negedge clk);
    clear = 1'b1;
    dp_if.gp_enable     = 16'h0080;
    dp_if.gp_write_data = 32'd7;
    dp_if.gp_register_select = 4'd7;
    step();
    expect_all_regs("post_clr");
    expect_bus("post_clr");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_path
